// File: rtl/dstream_fifo.sv
// dstream_fifo: first-word-fall-through buffer for the valid/ready data stream.
// Absorbs rate mismatch between a producer and a consumer. It also reports
// the fill level and an almost-full warning. It can drop words on full and
// keep a sticky overflow flag. A synchronous flush empties it.
module dstream_fifo #(
  parameter int N              = 16,
  parameter int DEPTH          = 8,
  parameter int ALMOST_FULL    = 6,
  parameter int DROP_WHEN_FULL = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;

  // All handshake status comes from the registered level only, so there is
  // no combinational path from in_valid/out_ready to any output.
  assign full        = (level == LW'(DEPTH));
  assign in_ready    = (DROP_WHEN_FULL != 0) ? 1'b1 : ~full;
  assign out_valid   = (level != '0);
  assign almost_full = (level >= LW'(ALMOST_FULL));
  assign out_data    = mem[rd_ptr];

  // Full is judged at the start of the cycle. In drop mode, a word that
  // arrives while full is discarded even if a pop frees a slot in the same cycle.
  assign push = in_valid & in_ready & ~full;
  assign pop  = out_valid & out_ready;

  // Storage write. It has no reset, and a flush in the same cycle suppresses it.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointer and level bookkeeping. Flush has priority over push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky drop flag. Only flush or reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if ((DROP_WHEN_FULL != 0) && in_valid && full) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dstream_fifo.sv
// Self-checking bench for dstream_fifo: table-driven vectors plus directed
// sequences and a scoreboarded random run. Two instances share the stimulus,
// one in backpressure mode and one in drop-on-full mode.
module tb_dstream_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        bp_in_ready, bp_out_valid, bp_af, bp_ovf;
  logic [15:0] bp_out_data;
  logic [3:0]  bp_level;
  logic        dr_in_ready, dr_out_valid, dr_af, dr_ovf;
  logic [15:0] dr_out_data;
  logic [3:0]  dr_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dstream_fifo #(.N(16), .DEPTH(8), .ALMOST_FULL(6), .DROP_WHEN_FULL(0)) u_bp (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(bp_in_ready), .in_data(in_data),
    .out_valid(bp_out_valid), .out_ready(out_ready), .out_data(bp_out_data),
    .level(bp_level), .almost_full(bp_af), .overflow(bp_ovf)
  );

  dstream_fifo #(.N(16), .DEPTH(8), .ALMOST_FULL(6), .DROP_WHEN_FULL(1)) u_drop (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(dr_in_ready), .in_data(in_data),
    .out_valid(dr_out_valid), .out_ready(out_ready), .out_data(dr_out_data),
    .level(dr_level), .almost_full(dr_af), .overflow(dr_ovf)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic        orr;
    logic [15:0] d;
    logic        e_ov;
    logic [15:0] e_od;
    logic [3:0]  e_lvl;
    logic        e_ir;
    logic        e_af;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic fl, input logic iv, input logic orr, input logic [15:0] d,
                     input logic e_ov, input logic [15:0] e_od, input logic [3:0] e_lvl,
                     input logic e_ir, input logic e_af);
    vec_t v;
    v.fl = fl; v.iv = iv; v.orr = orr; v.d = d;
    v.e_ov = e_ov; v.e_od = e_od; v.e_lvl = e_lvl; v.e_ir = e_ir; v.e_af = e_af;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] q[$];
    logic        iv_r;
    logic [15:0] d_r;
    logic        pending;
    logic        do_push, do_pop;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Vector table: fill/drain through almost-full and full, then flush vs push.
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 1, 0, 16'(i), i > 1, 16'h0001, 4'(i-1), 1, (i-1) >= 6);
    add(0, 1, 0, 16'h0099, 1, 16'h0001, 8, 0, 1);
    for (int j = 0; j < 8; j++)
      add(0, 0, 1, 16'h0000, 1, 16'(j+1), 4'(8-j), j != 0, (8-j) >= 6);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0);
    for (int k = 0; k < 5; k++)
      add(0, 1, 0, 16'h0A00 + 16'(k), k > 0, 16'h0A00, 4'(k), 1, 0);
    add(1, 1, 0, 16'h0BAD, 1, 16'h0A00, 5, 1, 0);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0);
    add(0, 1, 0, 16'h0C00, 0, 16'h0000, 0, 1, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h0C00, 1, 1, 0);
    add(0, 0, 1, 16'h0000, 1, 16'h0C00, 1, 1, 0);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0);

    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk);
      flush = tbl[i].fl; in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].orr;
      #1;
      chk($sformatf("vec%0d level", i), 32'(bp_level), 32'(tbl[i].e_lvl));
      chk($sformatf("vec%0d out_valid", i), 32'(bp_out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d in_ready", i), 32'(bp_in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("vec%0d almost_full", i), 32'(bp_af), 32'(tbl[i].e_af));
      chk($sformatf("vec%0d overflow", i), 32'(bp_ovf), 32'(0));
      if (tbl[i].e_ov)
        chk($sformatf("vec%0d out_data", i), 32'(bp_out_data), 32'(tbl[i].e_od));
    end

    // Streaming: push and pop every cycle for 20 cycles, so the pointers wrap twice.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b1; in_data = 16'h0100 + 16'(i); out_ready = 1'b1;
      #1;
      if (i == 0) begin
        chk("stream level0", 32'(bp_level), 32'(0));
      end else begin
        chk($sformatf("stream%0d level", i), 32'(bp_level), 32'(1));
        chk($sformatf("stream%0d data", i), 32'(bp_out_data), 32'(16'h0100 + 16'(i-1)));
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("stream tail data", 32'(bp_out_data), 32'(16'h0113));
    chk("stream tail level", 32'(bp_level), 32'(1));
    @(negedge clk);
    #1;
    chk("stream empty", 32'(bp_level), 32'(0));

    // Asynchronous reset in the middle of a transfer.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h0500 + 16'(i); out_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre-reset level", 32'(bp_level), 32'(3));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset level", 32'(bp_level), 32'(0));
    chk("async reset out_valid", 32'(bp_out_valid), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Drop-on-full: overflow sets, dropped words never reach the output.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'(i+1); out_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hDEAD; out_ready = 1'b0;
    #1;
    chk("drop full level", 32'(dr_level), 32'(8));
    chk("drop in_ready", 32'(dr_in_ready), 32'(1));
    chk("drop ovf before", 32'(dr_ovf), 32'(0));
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1;
    #1;
    chk("drop ovf set", 32'(dr_ovf), 32'(1));
    chk("drop level held", 32'(dr_level), 32'(8));
    chk("drop head", 32'(dr_out_data), 32'(1));
    for (int j = 2; j <= 8; j++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk($sformatf("drop drain%0d data", j), 32'(dr_out_data), 32'(j));
      chk($sformatf("drop drain%0d level", j), 32'(dr_level), 32'(9-j));
    end
    @(negedge clk);
    out_ready = 1'b0; flush = 1'b1;
    #1;
    chk("drop empty", 32'(dr_level), 32'(0));
    chk("drop ovf sticky", 32'(dr_ovf), 32'(1));
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("drop ovf flushed", 32'(dr_ovf), 32'(0));

    // Random traffic against a queue scoreboard, following the stream hold rule.
    do_reset();
    pending = 1'b0; iv_r = 1'b0; d_r = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (!pending) begin
        iv_r = 1'($urandom_range(0, 1));
        d_r  = 16'($urandom);
      end
      in_valid = iv_r; in_data = d_r; out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rnd level", 32'(bp_level), 32'(q.size()));
      chk("rnd in_ready", 32'(bp_in_ready), 32'(q.size() < 8));
      if (q.size() != 0)
        chk("rnd out_data", 32'(bp_out_data), 32'(q[0]));
      do_push = iv_r && (q.size() < 8);
      do_pop  = (q.size() != 0) && out_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d_r);
      pending = iv_r && !do_push;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dstream_fifo.md
Name: dstream_fifo

Overview:
- Parametrised first-word-fall-through buffer for the team's valid/ready data stream.
- Sits between any stream producer (e.g. microphone sample decimator) and any consumer to absorb rate mismatch and backpressure.
- Adds what the plain stream handshake lacks: depth, fill level, almost-full warning, optional drop-on-full mode with sticky overflow flag, synchronous flush.

Parameters:
N, 16, data width in bits (>=1).
DEPTH, 8, number of entries; power of two, >=2.
ALMOST_FULL, 6, level at or above which almost_full asserts (1..DEPTH).
DROP_WHEN_FULL, 0, 0 = backpressure when full; 1 = in_ready always high, words arriving while full are discarded.

Ports:
clk  input  1  system clock, all state on rising edge.
reset_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of contents and overflow flag.
in_valid  input  1  producer word valid (stream "in" side).
in_ready  output  1  FIFO accepts word this cycle.
in_data  input  N  producer word.
out_valid  output  1  FIFO holds a word for consumer (stream "out" side).
out_ready  input  1  consumer accepts word this cycle.
out_data  output  N  head word.
level  output  $clog2(DEPTH+1)  current entry count, 0..DEPTH.
almost_full  output  1  level >= ALMOST_FULL.
overflow  output  1  sticky: a word was dropped (DROP_WHEN_FULL=1 only).

Behaviour:
- Reset (reset_n low, asynchronous): wr_ptr = rd_ptr = 0, level = 0, overflow = 0. Hence out_valid = 0, almost_full = 0, in_ready = 1. Storage array is not reset.
- push = in_valid & in_ready & ~full.
- pop = out_valid & out_ready.
- full = (level == DEPTH).
- in_ready: DROP_WHEN_FULL=0 -> ~full; DROP_WHEN_FULL=1 -> constant 1. Combinational from level only, never from in_valid.
- out_valid = (level != 0).
- out_data = mem[rd_ptr], combinational from the registered array. Undefined when out_valid = 0, but must not change while out_valid=1 and out_ready=0.
- Latency: a word pushed in cycle k is visible on out_valid/out_data in cycle k+1. No same-cycle bypass when empty.
- Level update, one step per cycle:
  - push only: level+1.
  - pop only: level-1.
  - push and pop together: level unchanged. Legal at any level 1..DEPTH-1; at DEPTH, push cannot occur.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Full, DROP_WHEN_FULL=1, in_valid=1: word discarded, overflow set to 1, state otherwise unchanged. A simultaneous pop still occurs; the incoming word is still dropped because full is evaluated at the start of the cycle.
- Full, DROP_WHEN_FULL=0: in_ready=0; producer must hold its word (stream rule: in_valid/in_data stable until accepted).
- Stream rules on output: once out_valid=1 it stays 1 with the same out_data until pop.
- Flush: at the next edge, pointers and level go to 0 and overflow to 0. Flush overrides any push/pop in the same cycle; that word is lost and that pop is void. overflow is cleared only by flush or reset.
- almost_full and level are registered-derived (from level), no combinational path from inputs.
- Reset asserted mid-transfer: immediate clear; any in-flight word is lost.

Test Plan:
- Reset then idle, N=16, DEPTH=8 -> out_valid=0, in_ready=1, level=0, almost_full=0, overflow=0.
- Push 0x0001..0x0008 with out_ready=0 -> level=8, in_ready=0 after the 8th, almost_full from level 6. Then out_ready=1 -> words 0x0001..0x0008 emerge in order, one per cycle, level back to 0.
- Continuous in_valid=1 and out_ready=1 for 20 cycles, data incrementing from 0x0100 -> level holds at 1 after the first cycle, output is an exact in-order copy, pointers wrap twice.
- DROP_WHEN_FULL=1: fill with 8 words, push 0xDEAD while full -> overflow=1, level stays 8, 0xDEAD never appears at the output.
- Level 5 with flush=1 and in_valid=1 in the same cycle -> next cycle level=0, out_valid=0, overflow=0; the pushed word is absent.
- Random in_valid/out_ready at 50% each, 10k cycles, against a scoreboard -> no loss, duplication or reordering; out_data stable whenever out_valid=1 and out_ready=0.
